pwm_bus_arbiter: RTL and testbench
==================================

PWM_BUS_ARBITER -- requirements
Module: pwm_bus_arbiter

Interface
REQ-001 Parameter: NUM_INST, default 4, number of PWM instances on the shared register bus (legal 1..8).
REQ-002 Port: clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 Port: rst_i  input  1  asynchronous reset, active-high.
REQ-004 Ports m0_req_i/m1_req_i  input  1  per-requester access request (m0 = SPI bridge, m1 = internal sequencer).
REQ-005 Ports m0_addr_i/m1_addr_i  input  8  [7:5] instance index, [4:0] register offset.
REQ-006 Ports m0_wdata_i/m1_wdata_i  input  8  write data.
REQ-007 Ports m0_write_i/m1_write_i  input  1  1 = write, 0 = read.
REQ-008 Ports m0_gnt_o/m1_gnt_o  output  1  one-cycle grant pulse; request accepted.
REQ-009 Ports m0_rdata_o/m1_rdata_o  output  8  read data, valid with rvalid.
REQ-010 Ports m0_rvalid_o/m1_rvalid_o  output  1  one-cycle completion pulse (reads and writes).
REQ-011 Port: b_addr_o  output  8  shared bus address = {3'b000, offset}.
REQ-012 Port: b_data_o  output  8  shared bus write data.
REQ-013 Port: b_write_o  output  1  write strobe.
REQ-014 Port: b_sel_o  output  NUM_INST  one-hot instance select.
REQ-015 Port: b_data_i  input  8*NUM_INST  read data, instance k on bits [8k+7:8k].
REQ-016 Port: err_o  output  1  sticky: access to instance index >= NUM_INST seen.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-018 Arbitration in IDLE: single requester wins; both requesting -> requester not granted last wins (round-robin); last-granted pointer reset value = m1 (so m0 wins first tie).
REQ-019 Winner's addr/wdata/write/id latched on IDLE->ACCESS edge; requester inputs ignored thereafter until next IDLE.
REQ-020 In ACCESS: winner's gnt_o = 1 for exactly that cycle; b_addr_o/b_data_o/b_sel_o driven from latched values; b_write_o = latched write.
REQ-021 Outside ACCESS: b_write_o = 0, b_sel_o = 0, b_addr_o/b_data_o hold last value.
REQ-022 End of ACCESS: rdata register captures b_data_i slice of selected instance (read), 0x00 (write).
REQ-023 In RESP: winner's rvalid_o = 1 for one cycle, rdata_o = captured value; loser's rvalid_o = 0.
REQ-024 Latency: req sampled in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2; max throughput one access per 3 cycles.
REQ-025 Requester holds req and fields stable until gnt; req dropped before gnt = request withdrawn, no access.
REQ-026 Requester still high after its own rvalid is re-arbitrated in next IDLE under round-robin.
REQ-027 Index >= NUM_INST: b_sel_o = 0, b_write_o = 0 in ACCESS, rdata = 0xFF, err_o set; normal gnt/rvalid timing kept.
REQ-028 err_o cleared only by reset.
REQ-029 rdata_o of non-winner holds its previous value.

Reset
REQ-030 rst_i high asynchronously forces IDLE; all gnt/rvalid/b_write_o/b_sel_o/err_o = 0; b_addr_o, b_data_o, rdata_o = 0x00; pointer = m1.
REQ-031 Reset during ACCESS or RESP aborts the transaction; no rvalid issued; pending requests re-arbitrated after release.

Verification
REQ-032 m0 write addr 0x23 data 0x5A -> gnt m0 at +1, b_sel_o=0b0010, b_addr_o=0x03, b_write_o=1 one cycle, m0_rvalid at +2 with rdata 0x00.
REQ-033 m1 read addr 0x41, b_data_i slice 2 = 0xC3 -> m1_rvalid at +2, m1_rdata_o = 0xC3, b_write_o stays 0.
REQ-034 m0 and m1 held high for 4 accesses -> grant order m0, m1, m0, m1; gnts 3 cycles apart.
REQ-035 NUM_INST=4, m0 write addr 0xA0 -> b_sel_o=0, no write strobe, rdata 0xFF on read, err_o=1 until reset.
REQ-036 rst_i asserted in ACCESS cycle -> outputs zero immediately, no rvalid; after release held request granted within 1 cycle.

Source files
------------

// File: rtl/pwm_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a shared PWM register bus.
// Each access is a fixed three-cycle sequence: arbitrate (IDLE), drive the
// bus for one cycle (ACCESS), return completion and read data (RESP).
//
// Handshake: a requester raises mX_req_i with addr/wdata/write stable and
// keeps them stable until mX_gnt_o pulses; the request is sampled only in
// IDLE, so dropping req before the grant withdraws it with no bus access.
// mX_gnt_o is a one-cycle accept pulse; mX_rvalid_o is a one-cycle
// completion pulse (reads and writes) one cycle later, with mX_rdata_o valid
// in that cycle and holding afterwards.
module pwm_bus_arbiter #(
    parameter int NUM_INST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [7:0]            m0_addr_i,
    input  logic [7:0]            m0_wdata_i,
    input  logic                  m0_write_i,
    output logic                  m0_gnt_o,
    output logic [7:0]            m0_rdata_o,
    output logic                  m0_rvalid_o,
    input  logic                  m1_req_i,
    input  logic [7:0]            m1_addr_i,
    input  logic [7:0]            m1_wdata_i,
    input  logic                  m1_write_i,
    output logic                  m1_gnt_o,
    output logic [7:0]            m1_rdata_o,
    output logic                  m1_rvalid_o,
    output logic [7:0]            b_addr_o,
    output logic [7:0]            b_data_o,
    output logic                  b_write_o,
    output logic [NUM_INST-1:0]   b_sel_o,
    input  logic [8*NUM_INST-1:0] b_data_i,
    output logic                  err_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;      // id of the requester granted last (1 = m1)
    logic        r_id;        // id of the current winner
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_write;
    logic [7:0]  r_rdata0;
    logic [7:0]  r_rdata1;
    logic        r_err;

    logic        w_any;
    logic        w_win_id;
    logic [2:0]  w_idx;
    logic        w_valid;
    logic [7:0]  w_slice;
    logic [7:0]  w_capture;

    assign w_any    = m0_req_i | m1_req_i;
    // On a tie the requester that was not granted last wins.
    assign w_win_id = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;

    assign w_idx     = r_addr[7:5];
    assign w_valid   = ({1'b0, w_idx} < 4'(NUM_INST));
    assign w_capture = r_write ? 8'h00 : (w_valid ? w_slice : 8'hFF);

    // Read-data mux: pick the byte lane of the selected instance.
    always_comb begin
        w_slice = 8'h00;
        for (int k = 0; k < NUM_INST; k++) begin
            if (w_idx == 3'(k)) begin
                w_slice = b_data_i[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        w_next_state = r_state;
        m0_gnt_o     = 1'b0;
        m1_gnt_o     = 1'b0;
        m0_rvalid_o  = 1'b0;
        m1_rvalid_o  = 1'b0;
        b_write_o    = 1'b0;
        b_sel_o      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = ST_RESP;
                m0_gnt_o     = ~r_id;
                m1_gnt_o     = r_id;
                // Out-of-range indices match no lane, so no select or strobe.
                for (int k = 0; k < NUM_INST; k++) begin
                    b_sel_o[k] = (w_idx == 3'(k));
                end
                b_write_o = r_write & w_valid;
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                m0_rvalid_o  = ~r_id;
                m1_rvalid_o  = r_id;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the winner on grant, capture read data and errors at end of ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_write  <= 1'b0;
            r_rdata0 <= 8'h00;
            r_rdata1 <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_id    <= w_win_id;
                r_last  <= w_win_id;
                r_addr  <= w_win_id ? m1_addr_i  : m0_addr_i;
                r_wdata <= w_win_id ? m1_wdata_i : m0_wdata_i;
                r_write <= w_win_id ? m1_write_i : m0_write_i;
            end
            if (r_state == ST_ACCESS) begin
                if (r_id) begin
                    r_rdata1 <= w_capture;
                end else begin
                    r_rdata0 <= w_capture;
                end
                if (!w_valid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Bus address/data come straight from the latched request, so they hold
    // their last value outside ACCESS.
    assign b_addr_o    = {3'b000, r_addr[4:0]};
    assign b_data_o    = r_wdata;
    assign m0_rdata_o  = r_rdata0;
    assign m1_rdata_o  = r_rdata1;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pwm_bus_arbiter.sv
// Bench for pwm_bus_arbiter: directed scenarios followed by random single
// transactions checked against a transaction-level reference model.
module tb_pwm_bus_arbiter;

    localparam int NUM_INST = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [7:0]            m0_addr_i = 8'h00, m1_addr_i = 8'h00;
    logic [7:0]            m0_wdata_i = 8'h00, m1_wdata_i = 8'h00;
    logic                  m0_write_i = 1'b0, m1_write_i = 1'b0;
    logic                  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [7:0]            m0_rdata_o, m1_rdata_o;
    logic [7:0]            b_addr_o, b_data_o;
    logic                  b_write_o;
    logic [NUM_INST-1:0]   b_sel_o;
    logic [8*NUM_INST-1:0] b_data_i = '0;
    logic                  err_o;
    logic [1:0]            dbg_state_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state: round-robin pointer, per-requester read data, error flag.
    int         exp_last = 1;
    logic [7:0] exp_rd[2];
    logic       exp_err = 1'b0;

    pwm_bus_arbiter #(.NUM_INST(NUM_INST)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_write_i(m0_write_i), .m0_gnt_o(m0_gnt_o), .m0_rdata_o(m0_rdata_o),
        .m0_rvalid_o(m0_rvalid_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_write_i(m1_write_i), .m1_gnt_o(m1_gnt_o), .m1_rdata_o(m1_rdata_o),
        .m1_rvalid_o(m1_rvalid_o),
        .b_addr_o(b_addr_o), .b_data_o(b_data_o), .b_write_o(b_write_o),
        .b_sel_o(b_sel_o), .b_data_i(b_data_i), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_i    = 1'b1;
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i    = 1'b0;
        exp_last = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        exp_err  = 1'b0;
    endtask

    // One arbitrated transaction from IDLE, checked cycle by cycle.
    task automatic do_txn(input logic r0, input logic r1,
                          input logic [7:0] a0, input logic [7:0] d0, input logic w0,
                          input logic [7:0] a1, input logic [7:0] d1, input logic w1,
                          input logic [31:0] bd);
        int         win;
        int         idx;
        logic [7:0] addr, wdata, exp_rdata;
        logic       wr, valid;
        logic [3:0] exp_sel;
        @(negedge clk_i);
        m0_req_i = r0; m0_addr_i = a0; m0_wdata_i = d0; m0_write_i = w0;
        m1_req_i = r1; m1_addr_i = a1; m1_wdata_i = d1; m1_write_i = w1;
        b_data_i = bd;
        if (r0 && r1) win = (exp_last == 1) ? 0 : 1;
        else          win = r1 ? 1 : 0;
        addr  = win ? a1 : a0;
        wdata = win ? d1 : d0;
        wr    = win ? w1 : w0;
        idx   = int'(addr[7:5]);
        valid = (idx < NUM_INST);
        exp_sel   = valid ? 4'(1 << idx) : 4'b0000;
        exp_rdata = wr ? 8'h00 : (valid ? bd[8*idx +: 8] : 8'hFF);
        exp_last  = win;
        if (!valid) exp_err = 1'b1;

        @(negedge clk_i);   // ACCESS
        check("gnt_winner", win ? m1_gnt_o : m0_gnt_o, 1);
        check("gnt_loser",  win ? m0_gnt_o : m1_gnt_o, 0);
        check("b_sel",      b_sel_o, exp_sel);
        check("b_addr",     b_addr_o, {3'b000, addr[4:0]});
        check("b_data",     b_data_o, wdata);
        check("b_write",    b_write_o, wr & valid);
        check("rvalid_acc", {m1_rvalid_o, m0_rvalid_o}, 0);
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;

        @(negedge clk_i);   // RESP
        check("rvalid_winner", win ? m1_rvalid_o : m0_rvalid_o, 1);
        check("rvalid_loser",  win ? m0_rvalid_o : m1_rvalid_o, 0);
        check("rdata_winner",  win ? m1_rdata_o : m0_rdata_o, exp_rdata);
        check("rdata_loser",   win ? m0_rdata_o : m1_rdata_o, exp_rd[1-win]);
        check("gnt_resp",      {m1_gnt_o, m0_gnt_o}, 0);
        check("b_sel_resp",    b_sel_o, 0);
        check("b_write_resp",  b_write_o, 0);
        check("b_addr_hold",   b_addr_o, {3'b000, addr[4:0]});
        check("err",           err_o, exp_err);
        exp_rd[win] = exp_rdata;
    endtask

    initial begin
        int         g_who[4];
        int         g_cyc[4];
        int         n_g;
        int         cyc;
        logic [7:0] ra0, ra1, rd0, rd1;
        logic       rr0, rr1, rw0, rw1;
        logic [2:0] ri;
        int         pick;

        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        // Reset state.
        @(negedge clk_i);
        check("rst_gnt",    {m1_gnt_o, m0_gnt_o}, 0);
        check("rst_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
        check("rst_b_sel",  b_sel_o, 0);
        check("rst_b_wr",   b_write_o, 0);
        check("rst_b_addr", b_addr_o, 0);
        check("rst_b_data", b_data_o, 0);
        check("rst_rdata",  {m1_rdata_o, m0_rdata_o}, 0);
        check("rst_err",    err_o, 0);
        check("rst_state",  dbg_state_o, 0);
        reset_dut();

        // No requests: nothing granted.
        repeat (3) begin
            @(negedge clk_i);
            check("idle_no_gnt", {m1_gnt_o, m0_gnt_o, b_write_o}, 0);
        end

        // m0 write 0x23 / 0x5A, then m1 read 0x41 with lane 2 = 0xC3.
        do_txn(1, 0, 8'h23, 8'h5A, 1, 8'h00, 8'h00, 0, 32'h1122_3344);
        do_txn(0, 1, 8'h00, 8'h00, 0, 8'h41, 8'h77, 0, 32'h55C3_6677);

        // Both requesters held high: alternate grants, three cycles apart.
        reset_dut();
        @(negedge clk_i);
        m0_req_i = 1'b1; m0_addr_i = 8'h01; m0_write_i = 1'b0;
        m1_req_i = 1'b1; m1_addr_i = 8'h22; m1_write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g_who[i] = -1;
            g_cyc[i] = -1;
        end
        n_g = 0;
        cyc = 0;
        while (n_g < 4 && cyc < 30) begin
            @(negedge clk_i);
            cyc++;
            if (m0_gnt_o || m1_gnt_o) begin
                g_who[n_g] = m1_gnt_o ? 1 : 0;
                g_cyc[n_g] = cyc;
                n_g++;
            end
        end
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        check("rr_count", n_g, 4);
        check("rr_first_lat", g_cyc[0], 1);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", g_who[i], i % 2);
            if (i > 0) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        repeat (2) @(negedge clk_i);

        // Out-of-range instance: no select, no strobe, 0xFF on read, sticky error.
        reset_dut();
        do_txn(1, 0, 8'hA0, 8'h99, 1, 8'h00, 8'h00, 0, 32'hDEAD_BEEF);
        do_txn(1, 0, 8'hA0, 8'h00, 0, 8'h00, 8'h00, 0, 32'hDEAD_BEEF);
        do_txn(0, 1, 8'h05, 8'h00, 0, 8'h25, 8'h00, 0, 32'h0000_AB00);
        check("err_sticky", err_o, 1);
        reset_dut();
        check("err_cleared", err_o, 0);

        // Reset in ACCESS aborts; held request granted right after release.
        @(negedge clk_i);
        m0_req_i = 1'b1; m0_addr_i = 8'h23; m0_wdata_i = 8'h5A; m0_write_i = 1'b1;
        @(negedge clk_i);
        check("abort_gnt_before", m0_gnt_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check("abort_gnt",    {m1_gnt_o, m0_gnt_o}, 0);
        check("abort_b_sel",  b_sel_o, 0);
        check("abort_b_wr",   b_write_o, 0);
        check("abort_b_addr", b_addr_o, 0);
        check("abort_b_data", b_data_o, 0);
        @(negedge clk_i);
        check("abort_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rearb_gnt",   m0_gnt_o, 1);
        check("rearb_b_wr",  b_write_o, 1);
        check("rearb_b_sel", b_sel_o, 4'b0010);
        m0_req_i = 1'b0;
        @(negedge clk_i);
        check("rearb_rvalid", m0_rvalid_o, 1);
        check("rearb_rdata",  m0_rdata_o, 8'h00);
        reset_dut();

        // Random transactions.
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(1, 3);
            rr0  = pick[0];
            rr1  = pick[1];
            ri   = 3'($urandom_range(0, 5));
            ra0  = {ri, 5'($urandom_range(0, 31))};
            ri   = 3'($urandom_range(0, 5));
            ra1  = {ri, 5'($urandom_range(0, 31))};
            rd0  = 8'($urandom);
            rd1  = 8'($urandom);
            rw0  = 1'($urandom);
            rw1  = 1'($urandom);
            do_txn(rr0, rr1, ra0, rd0, rw0, ra1, rd1, rw1, 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
